// File: rtl/decode_stage_if.sv
// Signal bundle between fetch/write-back (master side) and the RV32I decode stage (slave side).
interface decode_stage_if;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        wb_write_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        valid;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] store_data;
    logic [31:0] imm;
    logic [31:0] pc_out;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        illegal;

    modport master (
        output instr_valid, instruction, pc, stall, flush, wb_write_en, wb_rd, wb_data,
        input  valid, data1, data2, store_data, imm, pc_out, rs1, rs2, rd, alu_op,
               reg_write, mem_read, mem_write, is_branch, illegal
    );

    modport slave (
        input  instr_valid, instruction, pc, stall, flush, wb_write_en, wb_rd, wb_data,
        output valid, data1, data2, store_data, imm, pc_out, rs1, rs2, rd, alu_op,
               reg_write, mem_read, mem_write, is_branch, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: 32x32 register file with write-back bypass, instruction decode,
// and a registered ID/EX stage with stall/flush.
module decode_stage #(
    parameter bit FORWARD_WB = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);
    localparam int DATA_W = 32;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] store_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        alu_op_e           alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              is_branch;
        logic              illegal;
    } idex_t;

    function automatic logic signed [DATA_W-1:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic signed [DATA_W-1:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic signed [DATA_W-1:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic signed [DATA_W-1:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'b0};
    endfunction

    // funct7[5] selects SUB only for register-register ops; ADDI has no subtract form.
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt,
                                               input logic is_reg);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [DATA_W-1:0] regs [32];

    logic [6:0]        opcode_p0;
    logic [2:0]        funct3_p0;
    logic              alt_p0;
    logic [4:0]        rs1_p0;
    logic [4:0]        rs2_p0;
    logic [4:0]        rd_p0;
    logic [DATA_W-1:0] rs1_val_p0;
    logic [DATA_W-1:0] rs2_val_p0;
    logic              wb_hit_p0;
    logic              bubble_p0;
    idex_t             dec_p0;

    idex_t             idex_p1;
    logic              vld_p1;

    assign opcode_p0 = bus.instruction[6:0];
    assign funct3_p0 = bus.instruction[14:12];
    assign alt_p0    = bus.instruction[30];
    assign rs1_p0    = bus.instruction[19:15];
    assign rs2_p0    = bus.instruction[24:20];
    assign rd_p0     = bus.instruction[11:7];

    // x0 is never written, so its cleared entry keeps reading as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_write_en && (bus.wb_rd != 5'd0)) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign wb_hit_p0 = FORWARD_WB && bus.wb_write_en && (bus.wb_rd != 5'd0);

    always_comb begin
        rs1_val_p0 = regs[rs1_p0];
        rs2_val_p0 = regs[rs2_p0];
        if (wb_hit_p0 && (bus.wb_rd == rs1_p0)) begin
            rs1_val_p0 = bus.wb_data;
        end
        if (wb_hit_p0 && (bus.wb_rd == rs2_p0)) begin
            rs2_val_p0 = bus.wb_data;
        end
    end

    // ---- p0: decode ----
    always_comb begin
        dec_p0            = '0;
        dec_p0.data1      = rs1_val_p0;
        dec_p0.data2      = rs2_val_p0;
        dec_p0.store_data = rs2_val_p0;
        dec_p0.pc         = bus.pc;
        dec_p0.rs1        = rs1_p0;
        dec_p0.rs2        = rs2_p0;
        dec_p0.rd         = rd_p0;
        dec_p0.alu_op     = ALU_ADD;
        case (opcode_p0)
            OP_REG: begin
                dec_p0.alu_op    = alu_from_funct(funct3_p0, alt_p0, 1'b1);
                dec_p0.reg_write = 1'b1;
            end
            OP_IMM: begin
                dec_p0.alu_op    = alu_from_funct(funct3_p0, alt_p0, 1'b0);
                dec_p0.imm       = imm_i(bus.instruction);
                dec_p0.data2     = imm_i(bus.instruction);
                dec_p0.reg_write = 1'b1;
            end
            OP_LOAD: begin
                dec_p0.imm       = imm_i(bus.instruction);
                dec_p0.data2     = imm_i(bus.instruction);
                dec_p0.mem_read  = 1'b1;
                dec_p0.reg_write = 1'b1;
            end
            OP_STORE: begin
                dec_p0.imm       = imm_s(bus.instruction);
                dec_p0.data2     = imm_s(bus.instruction);
                dec_p0.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                dec_p0.alu_op    = ALU_SUB;
                dec_p0.imm       = imm_b(bus.instruction);
                dec_p0.is_branch = 1'b1;
            end
            OP_LUI: begin
                dec_p0.data1     = '0;
                dec_p0.imm       = imm_u(bus.instruction);
                dec_p0.data2     = imm_u(bus.instruction);
                dec_p0.reg_write = 1'b1;
            end
            default: begin
                dec_p0.illegal   = 1'b1;
            end
        endcase
    end

    // An empty fetch slot loads the same bubble as a flush; flush overrides stall.
    assign bubble_p0 = bus.flush || (!bus.stall && !bus.instr_valid);

    // ---- p1: ID/EX register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            idex_p1 <= '0;
        end else if (bubble_p0) begin
            vld_p1  <= 1'b0;
            idex_p1 <= '0;
        end else if (!bus.stall) begin
            vld_p1  <= 1'b1;
            idex_p1 <= dec_p0;
        end
    end

    assign bus.valid      = vld_p1;
    assign bus.data1      = idex_p1.data1;
    assign bus.data2      = idex_p1.data2;
    assign bus.store_data = idex_p1.store_data;
    assign bus.imm        = idex_p1.imm;
    assign bus.pc_out     = idex_p1.pc;
    assign bus.rs1        = idex_p1.rs1;
    assign bus.rs2        = idex_p1.rs2;
    assign bus.rd         = idex_p1.rd;
    assign bus.alu_op     = idex_p1.alu_op;
    assign bus.reg_write  = idex_p1.reg_write;
    assign bus.mem_read   = idex_p1.mem_read;
    assign bus.mem_write  = idex_p1.mem_write;
    assign bus.is_branch  = idex_p1.is_branch;
    assign bus.illegal    = idex_p1.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: table of hand-decoded instructions plus
// stall/flush and asynchronous-reset sequences.
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    decode_stage_if bus();

    decode_stage #(.FORWARD_WB(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] sd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [4:0]  ctl;   // {reg_write, mem_read, mem_write, is_branch, illegal}
    } exp_t;

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        iv;
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    localparam int NVEC = 13;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NVEC];
    exp_t zero_e;
    exp_t e_addi;
    exp_t e_add37;

    function automatic exp_t mke(input logic valid, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] sd, input logic [31:0] imm,
                                 input logic [31:0] pc, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [3:0] op, input logic [4:0] ctl);
        exp_t e;
        e.valid = valid; e.d1 = d1; e.d2 = d2; e.sd = sd; e.imm = imm; e.pc = pc;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.op = op; e.ctl = ctl;
        return e;
    endfunction

    // Valid rows carry the raw rs1/rs2 fields of the instruction; pc is filled per step.
    function automatic vec_t mk(input logic wb_en, input logic [4:0] wb_rd,
                                input logic [31:0] wb_data, input logic iv,
                                input logic [31:0] instr, input logic valid,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] sd, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [3:0] op,
                                input logic [4:0] ctl);
        vec_t v;
        v.wb_en = wb_en; v.wb_rd = wb_rd; v.wb_data = wb_data; v.iv = iv; v.instr = instr;
        if (valid)
            v.e = mke(1'b1, d1, d2, sd, imm, 32'h0, instr[19:15], instr[24:20], rd, op, ctl);
        else
            v.e = '0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, " valid"},  32'(bus.valid),  32'(e.valid));
        chk({tag, " data1"},  bus.data1,       e.d1);
        chk({tag, " data2"},  bus.data2,       e.d2);
        chk({tag, " store"},  bus.store_data,  e.sd);
        chk({tag, " imm"},    bus.imm,         e.imm);
        chk({tag, " pc_out"}, bus.pc_out,      e.pc);
        chk({tag, " rs1"},    32'(bus.rs1),    32'(e.rs1));
        chk({tag, " rs2"},    32'(bus.rs2),    32'(e.rs2));
        chk({tag, " rd"},     32'(bus.rd),     32'(e.rd));
        chk({tag, " alu_op"}, 32'(bus.alu_op), 32'(e.op));
        chk({tag, " ctl"},
            32'({bus.reg_write, bus.mem_read, bus.mem_write, bus.is_branch, bus.illegal}),
            32'(e.ctl));
    endtask

    task automatic drive(input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                         input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                         input logic stall, input logic flush);
        bus.wb_write_en = wb_en;
        bus.wb_rd       = wb_rd;
        bus.wb_data     = wb_data;
        bus.instr_valid = iv;
        bus.instruction = instr;
        bus.pc          = pc;
        bus.stall       = stall;
        bus.flush       = flush;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        zero_e = '0;
        //            wb  rd     wb_data       iv  instr         v  data1         data2         store         imm           rd     op     ctl
        vecs[0]  = mk(0, 5'd0, 32'h0,        1, 32'h00500093, 1, 32'h0,        32'h5,        32'h0,        32'h5,        5'd1,  4'd0, 5'b10000); // ADDI x1,x0,5
        vecs[1]  = mk(1, 5'd2, 32'hDEADBEEF, 1, 32'h002101B3, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        5'd3,  4'd0, 5'b10000); // ADD x3,x2,x2 bypass
        vecs[2]  = mk(1, 5'd0, 32'h7,        1, 32'h000001B3, 1, 32'h0,        32'h0,        32'h0,        32'h0,        5'd3,  4'd0, 5'b10000); // x0 write ignored
        vecs[3]  = mk(1, 5'd5, 32'h11,       0, 32'h00500093, 0, 32'h0,        32'h0,        32'h0,        32'h0,        5'd0,  4'd0, 5'b00000); // empty slot
        vecs[4]  = mk(1, 5'd6, 32'h100,      1, 32'h402283B3, 1, 32'h11,       32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        5'd7,  4'd1, 5'b10000); // SUB x7,x5,x2
        vecs[5]  = mk(0, 5'd0, 32'h0,        1, 32'hFE532E23, 1, 32'h100,      32'hFFFFFFFC, 32'h11,       32'hFFFFFFFC, 5'd28, 4'd0, 5'b00100); // SW x5,-4(x6)
        vecs[6]  = mk(0, 5'd0, 32'h0,        1, 32'h00832403, 1, 32'h100,      32'h8,        32'h0,        32'h8,        5'd8,  4'd0, 5'b11000); // LW x8,8(x6)
        vecs[7]  = mk(0, 5'd0, 32'h0,        1, 32'hFE6288E3, 1, 32'h11,       32'h100,      32'h100,      32'hFFFFFFF0, 5'd17, 4'd1, 5'b00010); // BEQ x5,x6,-16
        vecs[8]  = mk(0, 5'd0, 32'h0,        1, 32'h123454B7, 1, 32'h0,        32'h12345000, 32'h0,        32'h12345000, 5'd9,  4'd0, 5'b10000); // LUI x9,0x12345
        vecs[9]  = mk(0, 5'd0, 32'h0,        1, 32'h40415513, 1, 32'hDEADBEEF, 32'h404,      32'h0,        32'h404,      5'd10, 4'd9, 5'b10000); // SRAI x10,x2,4
        vecs[10] = mk(0, 5'd0, 32'h0,        1, 32'h0062B5B3, 1, 32'h11,       32'h100,      32'h100,      32'h0,        5'd11, 4'd6, 5'b10000); // SLTU x11,x5,x6
        vecs[11] = mk(0, 5'd0, 32'h0,        1, 32'h0000007F, 1, 32'h0,        32'h0,        32'h0,        32'h0,        5'd0,  4'd0, 5'b00001); // illegal
        vecs[12] = mk(0, 5'd0, 32'h0,        1, 32'hFFF2C613, 1, 32'h11,       32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 5'd12, 4'd4, 5'b10000); // XORI x12,x5,-1

        reset = 1'b1;
        drive(0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", zero_e);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            exp_t e;
            logic [31:0] pc;
            pc = 32'h1000 + 32'(4 * i);
            e = vecs[i].e;
            if (e.valid) e.pc = pc;
            drive(vecs[i].wb_en, vecs[i].wb_rd, vecs[i].wb_data, vecs[i].iv, vecs[i].instr, pc, 0, 0);
            tick();
            chk_out($sformatf("vec%0d", i), e);
        end

        // Stall holds the ID/EX register while the register file still accepts x7.
        e_addi = mke(1'b1, 32'h0, 32'h5, 32'h11, 32'h5, 32'h200, 5'd0, 5'd5, 5'd1, 4'd0, 5'b10000);
        drive(0, 5'd0, 32'h0, 1, 32'h00500093, 32'h200, 0, 0);
        tick();
        chk_out("pre_stall", e_addi);
        drive(1, 5'd7, 32'h77, 1, 32'h0062B5B3, 32'h204, 1, 0);
        tick();
        chk_out("stall1", e_addi);
        drive(0, 5'd0, 32'h0, 0, 32'hFE532E23, 32'h208, 1, 0);
        tick();
        chk_out("stall2", e_addi);
        drive(0, 5'd0, 32'h0, 1, 32'h0000007F, 32'h20C, 1, 0);
        tick();
        chk_out("stall3", e_addi);

        e_add37 = mke(1'b1, 32'h77, 32'h0, 32'h0, 32'h0, 32'h210, 5'd7, 5'd0, 5'd3, 4'd0, 5'b10000);
        drive(0, 5'd0, 32'h0, 1, 32'h000381B3, 32'h210, 0, 0);
        tick();
        chk_out("after_stall", e_add37);

        drive(0, 5'd0, 32'h0, 1, 32'h00500093, 32'h214, 1, 1);
        tick();
        chk_out("stall_flush", zero_e);

        drive(0, 5'd0, 32'h0, 1, 32'h000381B3, 32'h210, 0, 0);
        tick();
        chk_out("reload", e_add37);
        drive(0, 5'd0, 32'h0, 1, 32'h00500093, 32'h218, 0, 1);
        tick();
        chk_out("flush", zero_e);

        // Reset mid-cycle must clear outputs before any clock edge.
        drive(0, 5'd0, 32'h0, 1, 32'h123454B7, 32'h300, 0, 0);
        tick();
        chk("lui valid", 32'(bus.valid), 32'h1);
        chk("lui data2", bus.data2, 32'h12345000);
        #2 reset = 1'b1;
        #1 chk_out("async_reset", zero_e);
        #2 reset = 1'b0;

        for (int r = 1; r < 32; r++) begin
            logic [4:0]  ra;
            logic [31:0] ins;
            ra  = 5'(r);
            ins = {7'b0, ra, ra, 3'b000, 5'd1, 7'b0110011};
            drive(0, 5'd0, 32'h0, 1, ins, 32'h400, 0, 0);
            tick();
            chk($sformatf("cleared x%0d d1", r), bus.data1, 32'h0);
            chk($sformatf("cleared x%0d d2", r), bus.data2, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
